// File: rtl/crc8_serial_framer.sv
// Bit-serial framer: forwards DATA_BITS payload bits, then appends an MSB-first CRC-8.
// Optional macro CRC8_FINAL_XOR_EN inverts the appended CRC bits (final XOR with 8'hFF).
module crc8_serial_framer #(
  parameter int         DATA_BITS = 16,
  parameter logic [7:0] POLY      = 8'h07,
  parameter logic [7:0] INIT      = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_bit,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

  localparam logic [15:0] LAST_IDX = 16'(DATA_BITS - 1);

  state_t      state_q, state_d;
  logic [7:0]  crc_q, crc_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  crc_cnt_q, crc_cnt_d;
  logic        out_bit_q, out_bit_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        slot_free, accept;

  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? POLY : 8'h00);
  endfunction

  function automatic logic crc_out_bit(input logic msb);
`ifdef CRC8_FINAL_XOR_EN
    return ~msb;
`else
    return msb;
`endif
  endfunction

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = slot_free && (state_q != CRC);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    bit_cnt_d   = bit_cnt_q;
    crc_cnt_d   = crc_cnt_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;
    if (accept) begin
      out_bit_d   = in_bit;
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      crc_d       = crc_step(crc_q, in_bit);
      // IDLE and DATA share the counter path; DATA_BITS==1 falls straight into CRC
      if (bit_cnt_q == LAST_IDX) begin
        bit_cnt_d = '0;
        state_d   = CRC;
      end else begin
        bit_cnt_d = bit_cnt_q + 16'd1;
        state_d   = DATA;
      end
    end else if (state_q == CRC && slot_free) begin
      out_bit_d   = crc_out_bit(crc_q[7]);
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      crc_d       = {crc_q[6:0], 1'b0};
      crc_cnt_d   = crc_cnt_q + 3'd1;
      if (crc_cnt_q == 3'd7) begin
        out_last_d  = 1'b1;
        crc_d       = INIT;
        crc_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = IDLE;
      end
    end else if (slot_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      bit_cnt_q   <= '0;
      crc_cnt_q   <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      bit_cnt_q   <= bit_cnt_d;
      crc_cnt_q   <= crc_cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_crc8_serial_framer.sv
// Randomized self-checking bench for crc8_serial_framer (default parameters, 16-bit frames).
// Expected CRCs come from polynomial long division of the payload by x^8+x^2+x+1.
module tb_crc8_serial_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_bit;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  crc8_serial_framer dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Remainder of payload*x^8 divided by the generator (INIT = 0).
  function automatic logic [7:0] crc_ref(input logic [15:0] p);
    logic [23:0] r;
    r = {p, 8'h00};
    for (int i = 23; i >= 8; i--)
      if (r[i]) r = r ^ (24'h107 << (i - 8));
`ifdef CRC8_FINAL_XOR_EN
    return r[7:0] ^ 8'hFF;
`else
    return r[7:0];
`endif
  endfunction

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_bit"}, out_bit, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  // Streams the given payloads; rnd randomizes in_valid/out_ready. Returns in_ready-low cycles.
  task automatic run_frames(input string tag, input logic [15:0] pl[$], input bit rnd,
                            output int rdy_low);
    bit   in_q[$];
    bit   ob[$];
    bit   ol[$];
    int   cyc;
    bit   prev_stall;
    logic pb, pv, pl_last;
    logic [15:0] pay;
    logic [7:0]  crc;
    logic [23:0] lastv;
    rdy_low = 0; cyc = 0; prev_stall = 0; pb = 0; pv = 0; pl_last = 0;
    foreach (pl[f])
      for (int i = 15; i >= 0; i--) in_q.push_back(pl[f][i]);
    while (ob.size() < pl.size() * 24 && cyc < 2000) begin
      @(posedge clk); #1;
      in_valid  = (in_q.size() > 0) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      in_bit    = (in_q.size() > 0) ? in_q[0] : 1'b0;
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check({tag, "_stall_valid"}, out_valid, pv);
        check({tag, "_stall_bit"}, out_bit, pb);
        check({tag, "_stall_last"}, out_last, pl_last);
      end
      if (!in_ready) rdy_low++;
      if (in_valid && in_ready) void'(in_q.pop_front());
      if (out_valid && out_ready) begin
        ob.push_back(out_bit);
        ol.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      pb = out_bit; pv = out_valid; pl_last = out_last;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check({tag, "_bit_count"}, ob.size(), pl.size() * 24);
    foreach (pl[f]) begin
      pay = '0; crc = '0; lastv = '0;
      if (ob.size() >= (f + 1) * 24) begin
        for (int i = 0; i < 24; i++) begin
          if (i < 16) pay = {pay[14:0], ob[f * 24 + i]};
          else        crc = {crc[6:0], ob[f * 24 + i]};
          lastv = {lastv[22:0], ol[f * 24 + i]};
        end
      end
      check($sformatf("%s_f%0d_payload", tag, f), pay, pl[f]);
      check($sformatf("%s_f%0d_crc", tag, f), crc, crc_ref(pl[f]));
      check($sformatf("%s_f%0d_last", tag, f), lastv, 24'h000001);
    end
  endtask

  initial begin
    logic [15:0] pl[$];
    int rl;

    // Reset values
    do_reset(2);
    check_idle("reset");
    check("reset_frame_cnt", frame_cnt, 0);

    // Partial frame killed by reset
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_bit = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("mid_busy", busy, 1);
    do_reset(3);
    check_idle("midrst");

    // Single frame after reset: CRC must restart from INIT
    pl = '{16'h0001};
    run_frames("single", pl, 1'b0, rl);
    check("single_crc_const", crc_ref(16'h0001),
`ifdef CRC8_FINAL_XOR_EN
          8'hF8);
`else
          8'h07);
`endif
    check("single_frame_cnt", frame_cnt, 1);
    check("single_rdy_low", rl, 8);

    // Back-to-back frames at full rate
    do_reset(1);
    pl = '{16'h0100, 16'h0001};
    run_frames("b2b", pl, 1'b0, rl);
    check("b2b_rdy_low", rl, 16);
    check("b2b_frame_cnt", frame_cnt, 2);
    check("b2b_crc0_const", crc_ref(16'h0100),
`ifdef CRC8_FINAL_XOR_EN
          8'hEA);
`else
          8'h15);
`endif

    // Random payloads with random source gaps and sink stalls
    pl = {};
    for (int f = 0; f < 4; f++) pl.push_back(16'($urandom));
    run_frames("rand", pl, 1'b1, rl);
    check("rand_frame_cnt", frame_cnt, 6);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rand_drained", out_valid, 0);

    // frame_cnt wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("wrap_preload", frame_cnt, 16'hFFFF);
    pl = '{16'($urandom)};
    run_frames("wrap", pl, 1'b0, rl);
    check("wrap_frame_cnt", frame_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc8_serial_framer.md
Name: crc8_serial_framer

Overview:
- Serial-stream framer that feeds the bit-level XOR/parity datapath.
- Accepts a stream of DATA_BITS payload bits, forwards each bit through a one-entry registered output slot, and accumulates a CRC-8 with an MSB-first XOR-feedback shift register.
- After the last payload bit it appends the 8 CRC bits to the output stream and flags the final bit, then re-arms for the next frame.
- Both sides use valid/ready handshakes; full backpressure is supported.

Parameters:
- DATA_BITS, 16, payload bits per frame; legal range 1..65535.
- POLY, 8'h07, CRC-8 generator polynomial; the implicit x^8 term is omitted.
- INIT, 8'h00, CRC register value at reset and at the start of every frame.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_bit  input  1  payload bit.
- in_valid  input  1  in_bit is valid.
- in_ready  output  1  block accepts in_bit this cycle.
- out_bit  output  1  registered output bit: payload, then CRC.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts out_bit this cycle.
- out_last  output  1  qualifies the final CRC bit of a frame.
- busy  output  1  high while a frame is in progress (state != IDLE).
- frame_cnt  output  16  count of completed frames; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, crc=INIT, bit_cnt=0, crc_cnt=0, out_bit=0, out_valid=0, out_last=0, frame_cnt=0.
  - Reset overrides all other activity, including mid-frame or mid-CRC; any partial frame is discarded with no CRC emitted.
- slot_free = !out_valid || out_ready (output register empty or draining this cycle).
- in_ready = slot_free && (state != CRC). The value is combinational and does not depend on in_valid.
- Accept = in_valid && in_ready. On accept:
  - out_bit <= in_bit, out_valid <= 1.
  - fb = crc[7] ^ in_bit; crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00).
  - bit_cnt increments.
- States:
  - IDLE: accept -> DATA. If DATA_BITS==1, go directly to CRC.
  - DATA: an accept with bit_cnt==DATA_BITS-1 -> CRC, and bit_cnt clears.
  - CRC: each cycle with slot_free, out_bit <= crc[7], out_valid <= 1, crc shifts left with 0 fill, and crc_cnt increments.
    - On the 8th CRC bit (crc_cnt==7): out_last <= 1, crc <= INIT, crc_cnt <= 0, frame_cnt += 1, state -> IDLE.
    - This bit is emitted before the transition to IDLE takes effect.
- If slot_free and nothing is loaded, out_valid <= 0 and out_last <= 0.
- out_last clears when the bit it qualifies is consumed, unless a new bit is loaded in the same cycle.
- Latency: an input bit appears on out_bit 1 cycle after acceptance.
- Throughput: 1 bit/clk with out_ready held high. A DATA_BITS frame occupies DATA_BITS+8 output cycles.
- Input is stalled during CRC; the first bit of the next frame is accepted in the cycle after the last CRC bit is loaded.
- Backpressure: while out_valid && !out_ready, out_bit, out_valid, out_last, crc and state all hold.
- in_valid low during DATA: the frame waits indefinitely with no timeout.

Optional Feature:
- Macro: CRC8_FINAL_XOR_EN.
- Defined: appended CRC bits are inverted (out_bit <= ~crc[7]). This is equivalent to a final XOR of 8'hFF; the internal CRC register is unaffected.
- Undefined: CRC bits are emitted uninverted; there is no extra logic.

Test Plan:
- Reset: hold rst for 3 clks mid-frame after 5 bits -> all outputs 0, busy=0; the next frame computes CRC from INIT.
- Single frame, defaults, payload 16'h0001 MSB-first, out_ready=1 -> 24 output bits: 16 payload bits then 8'h07 (00000111); out_last high only on bit 24; frame_cnt=1.
- Back-to-back frames 16'h0100 then 16'h0001 -> CRCs 8'h15 then 8'h07; in_ready low for exactly 8 cycles per frame; frame_cnt=2.
- Random out_ready (50%) and random in_valid, 4 frames -> stream identical to the unstalled case; no bit dropped or duplicated; outputs stable while stalled.
- CRC8_FINAL_XOR_EN defined, payload 16'h0001 -> appended CRC 8'hF8.
- frame_cnt preloaded by forcing it to 16'hFFFF, then complete one frame -> frame_cnt=0.
